// File: rtl/rab_lookup_arb.sv
// rab_lookup_arb
// ----------------------------------------------------------------------------
// Shares one slice_top lookup engine between N_PORTS translation requesters.
// Each lookup runs IDLE -> LOOKUP -> RESP. A round-robin arbiter picks the
// requester, the request is captured and presented to the engine, the engine
// result is classified, and the answer is returned on the granted port.
//
// Optional feature: define RAB_ARB_PERF_EN to build the saturating
// perf_lookups / perf_misses counters. Without it both outputs read 0.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn    clock, asynchronous active-low reset
//   req_valid/req_ready          per-port request handshake
//   req_addr_min/max, rw, id     per-port request payload (flattened vectors)
//   lu_addr_min/max, lu_rw       captured request presented to slice_top
//   lu_hit_any/prot_any/multi    slice_top result flags
//   lu_out_addr                  slice_top translated address
//   rsp_valid/rsp_ready          one-hot response handshake
//   rsp_addr, rsp_status         translated address and status (OK/MISS/PROT/MULTI)
//   miss_valid/addr/id           one-cycle miss report to the miss handler
//   int_miss/int_prot/int_multi  one-cycle per-port interrupt pulses
//   perf_lookups, perf_misses    optional statistics counters
// ----------------------------------------------------------------------------
module rab_lookup_arb #(
    parameter int N_PORTS        = 3,
    parameter int C_AXI_ID_WIDTH = 8,
    parameter int PORT_ID_WIDTH  = 3
) (
    input  logic                                    s_axi_aclk,
    input  logic                                    s_axi_aresetn,
    input  logic [N_PORTS-1:0]                      req_valid,
    output logic [N_PORTS-1:0]                      req_ready,
    input  logic [N_PORTS*32-1:0]                   req_addr_min,
    input  logic [N_PORTS*32-1:0]                   req_addr_max,
    input  logic [N_PORTS-1:0]                      req_rw,
    input  logic [N_PORTS*C_AXI_ID_WIDTH-1:0]       req_id,
    output logic [31:0]                             lu_addr_min,
    output logic [31:0]                             lu_addr_max,
    output logic                                    lu_rw,
    input  logic                                    lu_hit_any,
    input  logic                                    lu_prot_any,
    input  logic                                    lu_multi,
    input  logic [31:0]                             lu_out_addr,
    output logic [N_PORTS-1:0]                      rsp_valid,
    input  logic [N_PORTS-1:0]                      rsp_ready,
    output logic [31:0]                             rsp_addr,
    output logic [1:0]                              rsp_status,
    output logic                                    miss_valid,
    output logic [31:0]                             miss_addr,
    output logic [PORT_ID_WIDTH+C_AXI_ID_WIDTH-1:0] miss_id,
    output logic [N_PORTS-1:0]                      int_miss,
    output logic [N_PORTS-1:0]                      int_prot,
    output logic [N_PORTS-1:0]                      int_multi,
    output logic [31:0]                             perf_lookups,
    output logic [31:0]                             perf_misses
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_MISS  = 2'b01;
    localparam logic [1:0] ST_PROT  = 2'b10;
    localparam logic [1:0] ST_MULTI = 2'b11;

    state_t                              state_reg;
    logic [PORT_ID_WIDTH-1:0]            ptr_reg;
    logic [31:0]                         cap_addr_min_reg;
    logic [31:0]                         cap_addr_max_reg;
    logic                                cap_rw_reg;
    logic [C_AXI_ID_WIDTH-1:0]           cap_id_reg;
    logic [PORT_ID_WIDTH-1:0]            cap_port_reg;
    logic [N_PORTS-1:0]                  rsp_valid_reg;
    logic [31:0]                         rsp_addr_reg;
    logic [1:0]                          rsp_status_reg;
    logic                                miss_valid_reg;
    logic [31:0]                         miss_addr_reg;
    logic [PORT_ID_WIDTH+C_AXI_ID_WIDTH-1:0] miss_id_reg;
    logic [N_PORTS-1:0]                  int_miss_reg;
    logic [N_PORTS-1:0]                  int_prot_reg;
    logic [N_PORTS-1:0]                  int_multi_reg;

    // Per-port views of the flattened payload buses.
    logic [31:0]               addr_min_arr [N_PORTS];
    logic [31:0]               addr_max_arr [N_PORTS];
    logic [C_AXI_ID_WIDTH-1:0] id_arr       [N_PORTS];
    logic [N_PORTS-1:0]        gnt_onehot;
    logic [N_PORTS-1:0]        port_sel;

    logic                      gnt_found;
    logic [PORT_ID_WIDTH-1:0]  gnt_idx;
    logic [31:0]               sel_addr_min;
    logic [31:0]               sel_addr_max;
    logic                      sel_rw;
    logic [C_AXI_ID_WIDTH-1:0] sel_id;
    logic                      rsp_ready_sel;
    logic [1:0]                status_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign addr_min_arr[gi] = req_addr_min[gi*32 +: 32];
            assign addr_max_arr[gi] = req_addr_max[gi*32 +: 32];
            assign id_arr[gi]       = req_id[gi*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH];
            assign gnt_onehot[gi]   = gnt_found && (gnt_idx == PORT_ID_WIDTH'(gi));
            assign port_sel[gi]     = (cap_port_reg == PORT_ID_WIDTH'(gi));
        end
    endgenerate

    // Round-robin search starting one past the last grant, wrapping once.
    always_comb begin
        int cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = int'(ptr_reg) + 1 + i;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = PORT_ID_WIDTH'(cand);
            end
        end
    end

    // One-hot mux of the granted payload and the captured port's rsp_ready.
    always_comb begin
        sel_addr_min  = '0;
        sel_addr_max  = '0;
        sel_rw        = 1'b0;
        sel_id        = '0;
        rsp_ready_sel = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt_onehot[i]) begin
                sel_addr_min = addr_min_arr[i];
                sel_addr_max = addr_max_arr[i];
                sel_rw       = req_rw[i];
                sel_id       = id_arr[i];
            end
            if (port_sel[i] && rsp_ready[i]) begin
                rsp_ready_sel = 1'b1;
            end
        end
    end

    // Result classification; a miss outranks multi-hit, which outranks prot.
    always_comb begin
        if (!lu_hit_any) begin
            status_next = ST_MISS;
        end else if (lu_multi) begin
            status_next = ST_MULTI;
        end else if (lu_prot_any) begin
            status_next = ST_PROT;
        end else begin
            status_next = ST_OK;
        end
    end

    // req_ready is gated by reset so every output reads 0 while reset is held.
    assign req_ready = (s_axi_aresetn && (state_reg == IDLE)) ? gnt_onehot : '0;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_reg        <= IDLE;
            ptr_reg          <= PORT_ID_WIDTH'(N_PORTS - 1);
            cap_addr_min_reg <= '0;
            cap_addr_max_reg <= '0;
            cap_rw_reg       <= 1'b0;
            cap_id_reg       <= '0;
            cap_port_reg     <= '0;
            rsp_valid_reg    <= '0;
            rsp_addr_reg     <= '0;
            rsp_status_reg   <= '0;
            miss_valid_reg   <= 1'b0;
            miss_addr_reg    <= '0;
            miss_id_reg      <= '0;
            int_miss_reg     <= '0;
            int_prot_reg     <= '0;
            int_multi_reg    <= '0;
        end else begin
            // Pulses last exactly one cycle, independent of response stalls.
            miss_valid_reg <= 1'b0;
            int_miss_reg   <= '0;
            int_prot_reg   <= '0;
            int_multi_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (gnt_found) begin
                        cap_addr_min_reg <= sel_addr_min;
                        cap_addr_max_reg <= sel_addr_max;
                        cap_rw_reg       <= sel_rw;
                        cap_id_reg       <= sel_id;
                        cap_port_reg     <= gnt_idx;
                        ptr_reg          <= gnt_idx;
                        state_reg        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state_reg      <= RESP;
                    rsp_valid_reg  <= port_sel;
                    rsp_status_reg <= status_next;
                    rsp_addr_reg   <= (status_next == ST_OK) ? lu_out_addr : 32'h0;
                    case (status_next)
                        ST_MISS: begin
                            miss_valid_reg <= 1'b1;
                            miss_addr_reg  <= cap_addr_min_reg;
                            miss_id_reg    <= {cap_port_reg, cap_id_reg};
                            int_miss_reg   <= port_sel;
                        end
                        ST_PROT:  int_prot_reg  <= port_sel;
                        ST_MULTI: int_multi_reg <= port_sel;
                        default: ;
                    endcase
                end
                RESP: begin
                    if (rsp_ready_sel) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign lu_addr_min = cap_addr_min_reg;
    assign lu_addr_max = cap_addr_max_reg;
    assign lu_rw       = cap_rw_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_addr    = rsp_addr_reg;
    assign rsp_status  = rsp_status_reg;
    assign miss_valid  = miss_valid_reg;
    assign miss_addr   = miss_addr_reg;
    assign miss_id     = miss_id_reg;
    assign int_miss    = int_miss_reg;
    assign int_prot    = int_prot_reg;
    assign int_multi   = int_multi_reg;

`ifdef RAB_ARB_PERF_EN
    logic [31:0] perf_lookups_reg;
    logic [31:0] perf_misses_reg;

    // Both counters advance on RESP entry and stick at all-ones.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            perf_lookups_reg <= '0;
            perf_misses_reg  <= '0;
        end else if (state_reg == LOOKUP) begin
            if (perf_lookups_reg != 32'hFFFF_FFFF) begin
                perf_lookups_reg <= perf_lookups_reg + 32'd1;
            end
            if ((status_next == ST_MISS) && (perf_misses_reg != 32'hFFFF_FFFF)) begin
                perf_misses_reg <= perf_misses_reg + 32'd1;
            end
        end
    end

    assign perf_lookups = perf_lookups_reg;
    assign perf_misses  = perf_misses_reg;
`else
    assign perf_lookups = 32'h0;
    assign perf_misses  = 32'h0;
`endif

endmodule

// File: tb/tb_rab_lookup_arb.sv
// Directed testbench for rab_lookup_arb (N_PORTS=3, ID width 8, port index 3).
module tb_rab_lookup_arb;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [95:0] req_addr_min;
    logic [95:0] req_addr_max;
    logic [2:0]  req_rw;
    logic [23:0] req_id;
    logic [31:0] lu_addr_min;
    logic [31:0] lu_addr_max;
    logic        lu_rw;
    logic        lu_hit_any;
    logic        lu_prot_any;
    logic        lu_multi;
    logic [31:0] lu_out_addr;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_status;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic [10:0] miss_id;
    logic [2:0]  int_miss;
    logic [2:0]  int_prot;
    logic [2:0]  int_multi;
    logic [31:0] perf_lookups;
    logic [31:0] perf_misses;

    int passed = 0;
    int total  = 0;

    rab_lookup_arb #(
        .N_PORTS(3), .C_AXI_ID_WIDTH(8), .PORT_ID_WIDTH(3)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr_min(req_addr_min), .req_addr_max(req_addr_max),
        .req_rw(req_rw), .req_id(req_id),
        .lu_addr_min(lu_addr_min), .lu_addr_max(lu_addr_max), .lu_rw(lu_rw),
        .lu_hit_any(lu_hit_any), .lu_prot_any(lu_prot_any),
        .lu_multi(lu_multi), .lu_out_addr(lu_out_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_status(rsp_status),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_id(miss_id),
        .int_miss(int_miss), .int_prot(int_prot), .int_multi(int_multi),
        .perf_lookups(perf_lookups), .perf_misses(perf_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one cycle; sample and drive 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int p, input logic [31:0] amin, input logic [31:0] amax,
                            input logic rw, input logic [7:0] id);
        req_addr_min[p*32 +: 32] = amin;
        req_addr_max[p*32 +: 32] = amax;
        req_rw[p]                = rw;
        req_id[p*8 +: 8]         = id;
    endtask

    // Compact single lookup with rsp_ready held high; expects OK or MISS.
    task automatic quick(input int p, input logic hit);
        logic [2:0] oh;
        oh = 3'(1 << p);
        req_valid = oh;
        #1;
        check($sformatf("quick_ready_p%0d", p), req_ready, oh);
        step();
        req_valid   = 3'b000;
        lu_hit_any  = hit;
        lu_multi    = 1'b0;
        lu_prot_any = 1'b0;
        lu_out_addr = 32'h4000_0000;
        step();
        check($sformatf("quick_status_p%0d", p), rsp_status, hit ? 2'b00 : 2'b01);
        step();
    endtask

    logic [2:0] rr_exp [6];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst_n = 1'b0;
        req_valid = '0; req_addr_min = '0; req_addr_max = '0; req_rw = '0; req_id = '0;
        lu_hit_any = 1'b0; lu_prot_any = 1'b0; lu_multi = 1'b0; lu_out_addr = '0;
        rsp_ready = 3'b111;
        set_port(0, 32'h0000_0100, 32'h0000_01FF, 1'b0, 8'h11);
        set_port(1, 32'h0000_1000, 32'h0000_103F, 1'b1, 8'h22);
        set_port(2, 32'h0000_2000, 32'h0000_20FF, 1'b0, 8'h5A);

        // Reset state with all three ports already requesting.
        req_valid = 3'b111;
        step(); step();
        check("rst_req_ready", req_ready, 3'b000);
        check("rst_rsp_valid", rsp_valid, 3'b000);
        check("rst_lu_addr_min", lu_addr_min, 32'h0);
        check("rst_miss_valid", miss_valid, 1'b0);
        check("rst_perf_lookups", perf_lookups, 32'h0);

        // Round-robin from reset: grants 0,1,2,0,1,2 three cycles apart.
        lu_hit_any  = 1'b1;
        lu_out_addr = 32'h9000_0000;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_grant_%0d", k), req_ready, rr_exp[k]);
            step();
            check($sformatf("rr_lookup_ready_%0d", k), req_ready, 3'b000);
            step();
            check($sformatf("rr_rsp_valid_%0d", k), rsp_valid, rr_exp[k]);
            step();
        end
        // Withdraw the request that would be granted next: it must not be taken.
        req_valid = 3'b000;
        #1;
        check("withdraw_ready", req_ready, 3'b000);
        step(); step();
        check("withdraw_no_rsp", rsp_valid, 3'b000);

        // Single port, no contention: port 1 hit.
        req_valid = 3'b010;
        #1;
        check("p1_req_ready", req_ready, 3'b010);
        step();
        req_valid   = 3'b000;
        lu_hit_any  = 1'b1; lu_multi = 1'b0; lu_prot_any = 1'b0;
        lu_out_addr = 32'h8000_1000;
        check("p1_lu_addr_min", lu_addr_min, 32'h0000_1000);
        check("p1_lu_addr_max", lu_addr_max, 32'h0000_103F);
        check("p1_lu_rw", lu_rw, 1'b1);
        check("p1_no_rsp_yet", rsp_valid, 3'b000);
        step();
        check("p1_rsp_valid", rsp_valid, 3'b010);
        check("p1_rsp_status", rsp_status, 2'b00);
        check("p1_rsp_addr", rsp_addr, 32'h8000_1000);
        check("p1_no_pulses", {miss_valid, int_miss, int_prot, int_multi}, 10'h0);
        step();
        check("p1_rsp_done", rsp_valid, 3'b000);

        // Miss path: port 2, id 0x5A; port 2 stalls one cycle while others are ready.
        req_valid = 3'b100;
        rsp_ready = 3'b011;
        #1;
        check("miss_req_ready", req_ready, 3'b100);
        step();
        req_valid   = 3'b000;
        lu_hit_any  = 1'b0;
        lu_out_addr = 32'hDEAD_BEEF;
        step();
        check("miss_status", rsp_status, 2'b01);
        check("miss_rsp_addr", rsp_addr, 32'h0);
        check("miss_valid_pulse", miss_valid, 1'b1);
        check("miss_addr", miss_addr, 32'h0000_2000);
        check("miss_id", miss_id, {3'd2, 8'h5A});
        check("miss_int", int_miss, 3'b100);
        step();
        check("miss_valid_once", miss_valid, 1'b0);
        check("miss_int_once", int_miss, 3'b000);
        check("miss_rsp_held", rsp_valid, 3'b100);
        rsp_ready = 3'b111;
        step();
        check("miss_rsp_done", rsp_valid, 3'b000);

        // Priority: multi outranks prot.
        req_valid = 3'b001;
        step();
        req_valid = 3'b000;
        lu_hit_any = 1'b1; lu_multi = 1'b1; lu_prot_any = 1'b1;
        step();
        check("multi_status", rsp_status, 2'b11);
        check("multi_int", int_multi, 3'b001);
        check("multi_no_other", {miss_valid, int_miss, int_prot}, 7'h0);
        check("multi_rsp_addr", rsp_addr, 32'h0);
        step();
        // Prot without multi.
        req_valid = 3'b010;
        step();
        req_valid = 3'b000;
        lu_hit_any = 1'b1; lu_multi = 1'b0; lu_prot_any = 1'b1;
        step();
        check("prot_status", rsp_status, 2'b10);
        check("prot_int", int_prot, 3'b010);
        check("prot_no_other", {miss_valid, int_miss, int_multi}, 7'h0);
        step();

        // Backpressure: port 0 miss with rsp_ready[0]=0 for 5 cycles.
        rsp_ready = 3'b110;
        req_valid = 3'b001;
        step();
        req_valid  = 3'b000;
        lu_hit_any = 1'b0; lu_prot_any = 1'b0;
        step();
        check("bp_pulse", int_miss, 3'b001);
        for (int c = 1; c < 5; c++) begin
            step();
            check($sformatf("bp_hold_%0d", c), {rsp_valid, int_miss}, {3'b001, 3'b000});
        end
        // Reset mid-RESP: outputs drop immediately.
        req_valid = 3'b111;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", rsp_valid, 3'b000);
        check("arst_req_ready", req_ready, 3'b000);
        check("arst_status_addr", {rsp_status, rsp_addr}, 34'h0);
        check("arst_lu", {lu_addr_min, lu_addr_max, lu_rw}, 65'h0);
        check("arst_miss", {miss_valid, miss_addr, miss_id}, 44'h0);
        step();
        rst_n = 1'b1;
        rsp_ready = 3'b111;
        #1;
        check("arst_first_grant", req_ready, 3'b001);
        step();
        lu_hit_any = 1'b1;
        step();
        check("arst_rsp_p0", rsp_valid, 3'b001);
        step();
        req_valid = 3'b000;

        // Three more lookups after reset: miss, miss, hit (4 total, 2 misses).
        quick(1, 1'b0);
        quick(2, 1'b0);
        quick(0, 1'b1);
`ifdef RAB_ARB_PERF_EN
        check("perf_lookups", perf_lookups, 32'd4);
        check("perf_misses", perf_misses, 32'd2);
`else
        check("perf_lookups_off", perf_lookups, 32'd0);
        check("perf_misses_off", perf_misses, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rab_lookup_arb.md
Name: rab_lookup_arb

Overview:
Time-multiplexes one shared slice_top lookup engine across N_PORTS translation requesters, replacing per-port lookup replication. Sits inside rab_core between the per-port port1/port2 select logic and a single slice_top instance. Sequences each lookup as request, lookup, then response. Classifies each result and raises per-port miss/prot/multi interrupt pulses.

Parameters:
N_PORTS, 3, number of requesting ports (1..8)
C_AXI_ID_WIDTH, 8, AXI ID width carried with each request
PORT_ID_WIDTH, 3, width of the granted-port index; must satisfy 2**PORT_ID_WIDTH >= N_PORTS

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset, asynchronous, active-low
req_valid  in  N_PORTS  per-port lookup request
req_ready  out  N_PORTS  per-port request accepted
req_addr_min  in  N_PORTS x 32  burst start address
req_addr_max  in  N_PORTS x 32  burst end address, inclusive
req_rw  in  N_PORTS  access type; 1 = write
req_id  in  N_PORTS x C_AXI_ID_WIDTH  AXI ID
lu_addr_min  out  32  to slice_top int_addr_min
lu_addr_max  out  32  to slice_top int_addr_max
lu_rw  out  1  to slice_top int_rw
lu_hit_any  in  1  OR of slice_top hit vector
lu_prot_any  in  1  OR of slice_top prot vector
lu_multi  in  1  slice_top multiple_hit
lu_out_addr  in  32  slice_top out_addr
rsp_valid  out  N_PORTS  one-hot response valid
rsp_ready  in  N_PORTS  per-port response consumed
rsp_addr  out  32  translated address; 0 unless status OK
rsp_status  out  2  00 OK, 01 MISS, 10 PROT, 11 MULTI
miss_valid  out  1  one-cycle miss pulse to the miss-handler registers
miss_addr  out  32  missing start address
miss_id  out  PORT_ID_WIDTH+C_AXI_ID_WIDTH  {port index, req_id}
int_miss, int_prot, int_multi  out  N_PORTS each  one-cycle interrupt pulses
perf_lookups  out  32  optional counter
perf_misses  out  32  optional counter

Behaviour:
- Reset: the FSM goes to IDLE. All outputs are 0. The round-robin pointer is N_PORTS-1, so port 0 wins first. Captured request registers are 0. Reset is asynchronous and aborts any lookup in flight; no response is issued for it.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - gnt = first port with req_valid set, searching from pointer+1 with wrap-around.
  - req_ready[gnt] is driven combinationally in the same cycle. Other req_ready bits stay 0.
  - On the handshake: capture addr_min, addr_max, rw, id and the port index; set the pointer to gnt; go to LOOKUP.
  - With no valid request, stay in IDLE.
- LOOKUP:
  - lu_* outputs are driven from the captured registers. They hold their last captured value in every state and stay stable at least one full cycle before sampling.
  - At the end of the cycle, sample the lu_* result inputs into the response registers and go to RESP.
- Classification, first match wins:
  - lu_hit_any = 0 gives MISS.
  - lu_multi = 1 gives MULTI.
  - lu_prot_any = 1 gives PROT.
  - Otherwise OK, and rsp_addr = lu_out_addr.
- RESP:
  - rsp_valid[port] stays high until rsp_ready[port]. On that handshake, return to IDLE.
  - rsp_ready on other ports is ignored.
- Pulses on RESP entry, one cycle only regardless of rsp_ready stall:
  - MISS: miss_valid and int_miss[port].
  - PROT: int_prot[port].
  - MULTI: int_multi[port].
- Latency: accept to rsp_valid is 2 cycles. Back-to-back throughput is one lookup per 3 cycles.
- Fairness: a continuously requesting port waits at most N_PORTS-1 other grants.
- req_valid deasserted before req_ready: the request is treated as withdrawn and is not captured.
- N_PORTS = 1: the pointer is constant and the grant is always port 0.

Optional Feature:
RAB_ARB_PERF_EN. When defined:
- perf_lookups increments on every RESP entry.
- perf_misses increments on every MISS entry.
- Both are 32-bit, saturate at 0xFFFFFFFF and reset to 0.
When undefined, both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Single port, no contention: port 1 requests min 0x1000 / max 0x103F, lu_hit_any=1 with lu_out_addr 0x8000_1000. Required: req_ready[1] in the request cycle, rsp_valid[1] 2 cycles later with status 00 and rsp_addr 0x8000_1000, no pulses.
- Round-robin, all 3 ports held valid from reset: grant order 0,1,2,0,1,2, with each grant 3 cycles apart while rsp_ready is held at 1.
- Miss path, port 2 with id 0x5A, addr 0x2000, lu_hit_any=0. Required: status 01, rsp_addr 0, miss_valid for exactly 1 cycle, miss_addr 0x2000, miss_id {2,0x5A}, int_miss = 3'b100.
- Priority: hit=1, multi=1, prot=1 gives status 11 with int_multi only. hit=1, multi=0, prot=1 gives status 10 with int_prot only.
- Backpressure and reset: hold rsp_ready[0]=0 for 5 cycles; rsp_valid[0] stays high and the pulse fires once. Then assert s_axi_aresetn low mid-RESP: all outputs are 0 in the same cycle, and after release port 0 is granted first.
- With RAB_ARB_PERF_EN: 4 lookups including 2 misses give perf_lookups=4 and perf_misses=2. Without the macro, both read 0.
